axi_lite_regfile: RTL and testbench
===================================

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width; only 32 or 64 are legal.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, register count (1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8))).
REQ-004 The block SHALL have parameter RO_MASK, default all-zero (NUM_REGS bits); bit i=1 makes register i read-only (status).
REQ-005 The block SHALL have ports: aclk  in  1  clock; areset  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have ports: saxi_awaddr in ADDR_WIDTH; saxi_awvalid in 1; saxi_awready out 1.
REQ-007 The block SHALL have ports: saxi_wdata in DATA_WIDTH; saxi_wstrb in DATA_WIDTH/8; saxi_wvalid in 1; saxi_wready out 1.
REQ-008 The block SHALL have ports: saxi_bresp out 2; saxi_bvalid out 1; saxi_bready in 1.
REQ-009 The block SHALL have ports: saxi_araddr in ADDR_WIDTH; saxi_arvalid in 1; saxi_arready out 1.
REQ-010 The block SHALL have ports: saxi_rdata out DATA_WIDTH; saxi_rresp out 2; saxi_rvalid out 1; saxi_rready in 1.
REQ-011 The block SHALL have ports: reg_out out NUM_REGS*DATA_WIDTH, RW register contents (register i at slice i); reg_in in NUM_REGS*DATA_WIDTH, status values for RO registers; wr_pulse out NUM_REGS, one-cycle strobe per committed write.

Function
REQ-012 Register index SHALL be awaddr/araddr >> log2(DATA_WIDTH/8); low address bits SHALL be ignored.
REQ-013 AW and W SHALL be accepted independently, in either order or together, each into a one-entry holding register.
REQ-014 saxi_awready SHALL be high iff the AW holding register is empty and saxi_bvalid is low; saxi_wready likewise for the W holding register.
REQ-015 In the cycle both holding registers are full, the write SHALL commit at that cycle's closing edge, both holding registers SHALL empty, and saxi_bvalid SHALL assert from the next cycle (AW+W handshake in cycle c -> bvalid in cycle c+2).
REQ-016 A commit SHALL update only byte lanes whose saxi_wstrb bit is 1; wstrb all-zero SHALL leave the register unchanged but still respond OKAY and pulse wr_pulse.
REQ-017 Index >= NUM_REGS or a RO_MASK register SHALL yield bresp SLVERR (2'b10), no register change, no wr_pulse; otherwise bresp OKAY (2'b00).
REQ-018 wr_pulse[i] SHALL be high for exactly the cycle after a successful commit to register i.
REQ-019 saxi_bvalid and saxi_bresp SHALL hold stable until saxi_bready is sampled high; bvalid clears at that edge.
REQ-020 saxi_arready SHALL be high iff saxi_rvalid is low; an AR handshake in cycle c SHALL produce saxi_rvalid with registered saxi_rdata/saxi_rresp in cycle c+1.
REQ-021 Read data SHALL be the stored value for RW registers and reg_in slice (sampled at the AR handshake edge) for RO registers; out-of-range SHALL return rdata 0 and rresp SLVERR.
REQ-022 saxi_rvalid, saxi_rdata and saxi_rresp SHALL hold stable until saxi_rready is sampled high; next AR accepted the cycle after.
REQ-023 Read and write channels SHALL operate concurrently; a read sampled on the same edge as a commit to the same register SHALL return the pre-write value.
REQ-024 No output SHALL depend combinationally on any input.

Reset
REQ-025 While areset is high at a clock edge: all RW registers, holding registers, saxi_rdata, saxi_bresp, saxi_rresp SHALL clear to 0; saxi_awready, saxi_wready, saxi_arready, saxi_bvalid, saxi_rvalid, wr_pulse SHALL be 0.
REQ-026 Reset mid-transaction SHALL discard held AW/W and pending B/R responses without committing; ready signals SHALL rise the first cycle after areset deasserts.

Structure
REQ-027 A shared package axi_lite_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and the strobe-width/index-shift helper constants.
REQ-028 The AW/W capture plus B response logic SHALL be a sub-module axi_lite_wr_channel; read path and register array stay in the top.

Verification
REQ-029 Verification SHALL cover: AW 0x04 and W 0xDEADBEEF, wstrb 0xF same cycle, bready high -> bvalid cycle c+2, bresp 00, reg_out[1]=0xDEADBEEF, wr_pulse[1] one cycle.
REQ-030 Verification SHALL cover: W 0x11223344 three cycles before AW 0x08, wstrb 0x5 onto 0xFFFFFFFF -> reg2=0xFF22FF44, OKAY.
REQ-031 Verification SHALL cover: write 0x40 (NUM_REGS=8) and write to RO register 3 -> bresp 10, no reg_out change, no wr_pulse; read 0x40 -> rdata 0, rresp 10.
REQ-032 Verification SHALL cover: read reg 3 with reg_in[3]=0xA5A5A5A5, rready low 5 cycles -> rvalid/rdata stable, arready low, completes on rready.
REQ-033 Verification SHALL cover: read and commit to reg 0 (old 0x1, new 0x2) on same edge -> rdata 0x1; subsequent read 0x2.
REQ-034 Verification SHALL cover: areset asserted with AW held, W not yet sent -> after reset, W alone produces no write and no bvalid.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite register file slice:
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   strb_width()            : byte-strobe width for a given data width
//   idx_shift()             : byte-address to register-index shift
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    // Only 32- and 64-bit data buses are legal, so the shift is 2 or 3.
    function automatic int idx_shift(input int data_width);
        return (data_width == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/axi_lite_wr_channel.sv
// ---------------------------------------------------------------------------
// axi_lite_wr_channel
// Captures AW and W independently into one-entry holding registers and
// produces the B response once both have arrived.
//   aclk, areset            : clock, synchronous active-high reset
//   saxi_aw* / saxi_w*      : AXI-Lite write address / data channels
//   saxi_b*                 : AXI-Lite write response channel
//   commit                  : both holds full, write lands at this cycle's edge
//   commit_addr/data/strb   : held write address, data and byte strobes
//   commit_err              : decode result from the register array (SLVERR)
// ---------------------------------------------------------------------------
module axi_lite_wr_channel
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   saxi_awaddr,
    input  logic                    saxi_awvalid,
    output logic                    saxi_awready,
    input  logic [DATA_WIDTH-1:0]   saxi_wdata,
    input  logic [DATA_WIDTH/8-1:0] saxi_wstrb,
    input  logic                    saxi_wvalid,
    output logic                    saxi_wready,
    output logic [1:0]              saxi_bresp,
    output logic                    saxi_bvalid,
    input  logic                    saxi_bready,
    output logic                    commit,
    output logic [ADDR_WIDTH-1:0]   commit_addr,
    output logic [DATA_WIDTH-1:0]   commit_data,
    output logic [DATA_WIDTH/8-1:0] commit_strb,
    input  logic                    commit_err
);

    logic up;
    logic aw_full;
    logic w_full;

    // 'up' keeps the ready outputs low for the first cycle after reset
    // without a combinational path from areset.
    assign saxi_awready = up && !aw_full && !saxi_bvalid;
    assign saxi_wready  = up && !w_full  && !saxi_bvalid;
    assign commit       = aw_full && w_full;

    always_ff @(posedge aclk) begin
        if (areset) begin
            up          <= 1'b0;
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            commit_addr <= '0;
            commit_data <= '0;
            commit_strb <= '0;
            saxi_bvalid <= 1'b0;
            saxi_bresp  <= RESP_OKAY;
        end else begin
            up <= 1'b1;
            if (commit) begin
                // Readies are low while both holds are full, so nothing new
                // can be captured on the commit edge.
                aw_full     <= 1'b0;
                w_full      <= 1'b0;
                saxi_bvalid <= 1'b1;
                saxi_bresp  <= commit_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (saxi_awvalid && saxi_awready) begin
                    aw_full     <= 1'b1;
                    commit_addr <= saxi_awaddr;
                end
                if (saxi_wvalid && saxi_wready) begin
                    w_full      <= 1'b1;
                    commit_data <= saxi_wdata;
                    commit_strb <= saxi_wstrb;
                end
                if (saxi_bvalid && saxi_bready) begin
                    saxi_bvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_regfile
// AXI4-Lite slave exposing NUM_REGS registers. Registers flagged in RO_MASK
// are read-only status words taken from reg_in; the rest are RW and driven
// out on reg_out.
//   aclk, areset   : clock, synchronous active-high reset
//   saxi_aw*/w*/b* : write channels (handled in axi_lite_wr_channel)
//   saxi_ar*/r*    : read channels
//   reg_out        : RW register contents, register i at slice i
//   reg_in         : status values for RO registers, register i at slice i
//   wr_pulse       : one-cycle strobe per successful write, per register
// ---------------------------------------------------------------------------
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_WIDTH = 8,
    parameter int                DATA_WIDTH = 32,
    parameter int                NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [ADDR_WIDTH-1:0]          saxi_awaddr,
    input  logic                           saxi_awvalid,
    output logic                           saxi_awready,
    input  logic [DATA_WIDTH-1:0]          saxi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        saxi_wstrb,
    input  logic                           saxi_wvalid,
    output logic                           saxi_wready,
    output logic [1:0]                     saxi_bresp,
    output logic                           saxi_bvalid,
    input  logic                           saxi_bready,
    input  logic [ADDR_WIDTH-1:0]          saxi_araddr,
    input  logic                           saxi_arvalid,
    output logic                           saxi_arready,
    output logic [DATA_WIDTH-1:0]          saxi_rdata,
    output logic [1:0]                     saxi_rresp,
    output logic                           saxi_rvalid,
    input  logic                           saxi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam int SHIFT  = idx_shift(DATA_WIDTH);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                  commit;
    logic                  commit_err;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]     commit_strb;

    axi_lite_wr_channel #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_channel (
        .aclk         (aclk),
        .areset       (areset),
        .saxi_awaddr  (saxi_awaddr),
        .saxi_awvalid (saxi_awvalid),
        .saxi_awready (saxi_awready),
        .saxi_wdata   (saxi_wdata),
        .saxi_wstrb   (saxi_wstrb),
        .saxi_wvalid  (saxi_wvalid),
        .saxi_wready  (saxi_wready),
        .saxi_bresp   (saxi_bresp),
        .saxi_bvalid  (saxi_bvalid),
        .saxi_bready  (saxi_bready),
        .commit       (commit),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data),
        .commit_strb  (commit_strb),
        .commit_err   (commit_err)
    );

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Write decode: the full shifted index is range-checked, the truncated
    // one selects the register.
    logic [ADDR_WIDTH-1:0] wr_idx_full;
    logic [IDX_W-1:0]      wr_sel;
    logic                  wr_in_range;

    assign wr_idx_full = commit_addr >> SHIFT;
    assign wr_sel      = wr_idx_full[IDX_W-1:0];
    assign wr_in_range = int'(wr_idx_full) < NUM_REGS;
    assign commit_err  = !wr_in_range || RO_MASK[wr_sel];

    // Read decode
    logic [ADDR_WIDTH-1:0] rd_idx_full;
    logic [IDX_W-1:0]      rd_sel;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_data_next;
    logic [1:0]            rd_resp_next;
    logic                  rd_up;

    assign rd_idx_full  = saxi_araddr >> SHIFT;
    assign rd_sel       = rd_idx_full[IDX_W-1:0];
    assign rd_in_range  = int'(rd_idx_full) < NUM_REGS;
    assign saxi_arready = rd_up && !saxi_rvalid;

    always_comb begin
        rd_data_next = '0;
        rd_resp_next = RESP_SLVERR;
        if (rd_in_range) begin
            rd_resp_next = RESP_OKAY;
            if (RO_MASK[rd_sel]) begin
                rd_data_next = reg_in[int'(rd_sel)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                rd_data_next = regs[rd_sel];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse    <= '0;
            rd_up       <= 1'b0;
            saxi_rvalid <= 1'b0;
            saxi_rdata  <= '0;
            saxi_rresp  <= RESP_OKAY;
        end else begin
            rd_up    <= 1'b1;
            wr_pulse <= '0;
            // An all-zero strobe still counts as a successful write.
            if (commit && !commit_err) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (commit_strb[b]) begin
                        regs[wr_sel][8*b +: 8] <= commit_data[8*b +: 8];
                    end
                end
                wr_pulse[wr_sel] <= 1'b1;
            end
            // Read data is sampled before any same-edge commit lands.
            if (saxi_arvalid && saxi_arready) begin
                saxi_rvalid <= 1'b1;
                saxi_rdata  <= rd_data_next;
                saxi_rresp  <= rd_resp_next;
            end else if (saxi_rvalid && saxi_rready) begin
                saxi_rvalid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regfile
// Self-checking bench for axi_lite_regfile (8 x 32-bit, register 3 RO).
// ---------------------------------------------------------------------------
module tb_axi_lite_regfile;

    localparam logic [7:0] RO_MASK_TB = 8'h08;

    logic         aclk = 1'b0;
    logic         areset;
    logic [7:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] reg_out;
    logic [255:0] reg_in;
    logic [7:0]   wr_pulse;

    axi_lite_regfile #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_REGS   (8),
        .RO_MASK    (RO_MASK_TB)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .saxi_awaddr  (awaddr),
        .saxi_awvalid (awvalid),
        .saxi_awready (awready),
        .saxi_wdata   (wdata),
        .saxi_wstrb   (wstrb),
        .saxi_wvalid  (wvalid),
        .saxi_wready  (wready),
        .saxi_bresp   (bresp),
        .saxi_bvalid  (bvalid),
        .saxi_bready  (bready),
        .saxi_araddr  (araddr),
        .saxi_arvalid (arvalid),
        .saxi_arready (arready),
        .saxi_rdata   (rdata),
        .saxi_rresp   (rresp),
        .saxi_rvalid  (rvalid),
        .saxi_rready  (rready),
        .reg_out      (reg_out),
        .reg_in       (reg_in),
        .wr_pulse     (wr_pulse)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mregs [8];
    logic [7:0]  ro_mask = RO_MASK_TB;

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 32'h0;
    endtask

    task automatic mdl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [7:0] pulse);
        int idx;
        idx = int'(a) / 4;
        if (idx >= 8 || ro_mask[idx]) begin
            resp  = 2'b10;
            pulse = 8'h00;
        end else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
            resp  = 2'b00;
            pulse = 8'(1 << idx);
        end
    endtask

    task automatic mdl_read(input logic [7:0] a, input logic [255:0] ri,
                            output logic [31:0] d, output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        if (idx >= 8) begin
            d = 32'h0; resp = 2'b10;
        end else if (ro_mask[idx]) begin
            d = ri[idx*32 +: 32]; resp = 2'b00;
        end else begin
            d = mregs[idx]; resp = 2'b00;
        end
    endtask

    function automatic logic [255:0] mdl_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = ro_mask[i] ? 32'h0 : mregs[i];
        return v;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output logic [7:0] pulse);
        int t;
        int hs_cyc;
        bit aw_done, w_done, go_aw, go_w;
        t = 0; hs_cyc = 0; aw_done = 0; w_done = 0;
        bready = (b_dly == 0);
        while (!(aw_done && w_done) && t < 40) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            go_aw   = awvalid && awready;
            go_w    = wvalid && wready;
            if (go_aw || go_w) hs_cyc = cyc;
            tick();
            t++;
            if (go_aw) aw_done = 1;
            if (go_w)  w_done  = 1;
        end
        awvalid = 0;
        wvalid  = 0;
        chk("wr_accept", {aw_done, w_done}, 2'b11);
        t = 0;
        while (!bvalid && t < 10) begin
            tick();
            t++;
        end
        chk("wr_bvalid", bvalid, 1'b1);
        chk("wr_latency", cyc - hs_cyc, 2);
        resp  = bresp;
        pulse = wr_pulse;
        for (int k = 0; k < b_dly; k++) begin
            tick();
            chk("b_hold", {bvalid, awready, wready, bresp, wr_pulse}, {1'b1, 1'b0, 1'b0, resp, 8'h00});
        end
        bready = 1;
        tick();
        chk("b_done", {bvalid, wr_pulse, awready, wready}, {1'b0, 8'h00, 1'b1, 1'b1});
    endtask

    task automatic axi_read(input logic [7:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        int t;
        t = 0;
        araddr  = addr;
        arvalid = 1;
        while (!arready && t < 20) begin
            tick();
            t++;
        end
        chk("ar_ready", arready, 1'b1);
        tick();
        arvalid = 0;
        chk("rd_rvalid", rvalid, 1'b1);
        data = rdata;
        resp = rresp;
        // reg_in is sampled at the AR edge; later changes must not leak in.
        reg_in = ~reg_in;
        for (int k = 0; k < r_dly; k++) begin
            tick();
            chk("r_hold", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, resp, data});
        end
        rready = 1;
        tick();
        rready = 0;
        chk("r_done", {rvalid, arready}, 2'b01);
    endtask

    // ---------------- directed write table ----------------
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        logic [1:0]  resp;
        logic [7:0]  pulse;
        int          chk_idx;
        logic [31:0] chk_val;
    } wr_vec_t;

    wr_vec_t vecs [8];

    initial begin
        logic [1:0]  resp, mresp;
        logic [7:0]  pulse, mpulse;
        logic [31:0] data, mdata;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        vecs[0] = '{8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 8'h02, 1, 32'hDEADBEEF};
        vecs[1] = '{8'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 2'b00, 8'h04, 2, 32'hFFFFFFFF};
        vecs[2] = '{8'h08, 32'h11223344, 4'h5, 3, 0, 0, 2'b00, 8'h04, 2, 32'hFF22FF44};
        vecs[3] = '{8'h40, 32'h12345678, 4'hF, 0, 0, 3, 2'b10, 8'h00, 1, 32'hDEADBEEF};
        vecs[4] = '{8'h0C, 32'hCAFEF00D, 4'hF, 1, 2, 0, 2'b10, 8'h00, 3, 32'h00000000};
        vecs[5] = '{8'h07, 32'h0000AB00, 4'h2, 2, 0, 1, 2'b00, 8'h02, 1, 32'hDEADABEF};
        vecs[6] = '{8'h00, 32'h00000001, 4'hF, 0, 1, 0, 2'b00, 8'h01, 0, 32'h00000001};
        vecs[7] = '{8'h14, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 2'b00, 8'h20, 5, 32'h00000000};

        areset = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        bready = 1; araddr = 0; arvalid = 0; rready = 0; reg_in = '0;
        mdl_reset();
        tick(); tick(); tick();
        chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, wr_pulse, bresp, rresp, rdata},
            '0);
        chk("reset_reg_out", reg_out, '0);
        areset = 0;
        tick();
        chk("ready_after_reset", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < 8; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly,
                      vecs[i].b_dly, resp, pulse);
            mdl_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mresp, mpulse);
            chk($sformatf("row%0d_bresp", i), resp, vecs[i].resp);
            chk($sformatf("row%0d_pulse", i), pulse, vecs[i].pulse);
            chk($sformatf("row%0d_reg", i), reg_out[vecs[i].chk_idx*32 +: 32], vecs[i].chk_val);
            chk($sformatf("row%0d_reg_out", i), reg_out, mdl_vec());
        end

        // Out-of-range read, RO read with a stalled rready, RW read.
        axi_read(8'h40, 0, data, resp);
        chk("rd_oob", {data, resp}, {32'h0, 2'b10});
        reg_in[3*32 +: 32] = 32'hA5A5A5A5;
        axi_read(8'h0C, 5, data, resp);
        chk("rd_ro_status", {data, resp}, {32'hA5A5A5A5, 2'b00});
        axi_read(8'h04, 1, data, resp);
        chk("rd_reg1", {data, resp}, {32'hDEADABEF, 2'b00});

        // Read sampled on the same edge as a commit to reg 0 (1 -> 2).
        awaddr = 8'h00; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 1;
        chk("same_edge_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 0; wvalid = 0;
        araddr = 8'h00; arvalid = 1;
        chk("same_edge_arready", arready, 1'b1);
        tick();
        arvalid = 0;
        chk("same_edge_rdata", {rvalid, rdata, bvalid, bresp}, {1'b1, 32'h1, 1'b1, 2'b00});
        rready = 1;
        tick();
        rready = 0;
        chk("same_edge_done", {rvalid, bvalid}, 2'b00);
        mdl_write(8'h00, 32'h2, 4'hF, mresp, mpulse);
        axi_read(8'h00, 0, data, resp);
        chk("same_edge_after", {data, resp}, {32'h2, 2'b00});

        // Reset while an AW is held: it must be discarded.
        awaddr = 8'h10; awvalid = 1;
        chk("held_aw_ready", awready, 1'b1);
        tick();
        awvalid = 0;
        areset = 1;
        tick();
        chk("midreset_outputs", {awready, wready, arready, bvalid, rvalid, wr_pulse}, '0);
        chk("midreset_reg_out", reg_out, '0);
        tick();
        areset = 0;
        tick();
        mdl_reset();
        chk("post_reset_ready", {awready, wready, arready}, 3'b111);
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
        tick();
        wvalid = 0;
        for (int k = 0; k < 6; k++) begin
            chk("w_only_no_write", {bvalid, wr_pulse}, '0);
            chk("w_only_reg_out", reg_out, mdl_vec());
            tick();
        end
        chk("w_only_holds", {awready, wready}, 2'b10);
        areset = 1;
        tick(); tick();
        areset = 0;
        tick();
        mdl_reset();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            a = 8'($urandom_range(0, 8'h4F));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                mdl_write(a, d, s, mresp, mpulse);
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2), resp, pulse);
                chk("rnd_bresp", resp, mresp);
                chk("rnd_pulse", pulse, mpulse);
                chk("rnd_reg_out", reg_out, mdl_vec());
            end else begin
                for (int i = 0; i < 8; i++) reg_in[i*32 +: 32] = $urandom;
                mdl_read(a, reg_in, mdata, mresp);
                axi_read(a, $urandom_range(0, 3), data, resp);
                chk("rnd_rdata", data, mdata);
                chk("rnd_rresp", resp, mresp);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
